// File: rtl/hv_similarity.sv
// hv_similarity: associative-memory classifier stage of the HDC seizure
// detector. Latches the XOR of the query against both class prototypes,
// popcounts CHUNK_WIDTH bits per class per cycle, then labels the query
// with the nearer prototype (1 = seizure; a tie resolves to non-seizure).
module hv_similarity #(
    parameter int DIMENSIONS  = 10000,
    parameter int CHUNK_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [DIMENSIONS-1:0] hv_test,
    input  logic [DIMENSIONS-1:0] hv_nonseizure,
    input  logic [DIMENSIONS-1:0] hv_seizure,
    output logic                  done,
    output logic                  label
);

    // Number of chunks; the last one may be partial.
    localparam int N_CHUNKS = (DIMENSIONS + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
    // Operand registers are padded to a whole number of chunks so that the
    // bits beyond DIMENSIONS read as zero.
    localparam int PAD_W    = N_CHUNKS * CHUNK_WIDTH;
    localparam int DIST_W   = $clog2(DIMENSIONS + 1);
    localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_COMPARE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [PAD_W-1:0]  r_xor_ns;
    logic [PAD_W-1:0]  r_xor_sz;
    logic [PAD_W-1:0]  w_xor_ns_in;
    logic [PAD_W-1:0]  w_xor_sz_in;
    logic [IDX_W-1:0]  r_idx;
    logic [DIST_W-1:0] r_dist_ns;
    logic [DIST_W-1:0] r_dist_sz;
    logic [DIST_W-1:0] w_pop_ns;
    logic [DIST_W-1:0] w_pop_sz;

    // Number of ones in one chunk; never exceeds CHUNK_WIDTH <= DIMENSIONS,
    // so it fits the accumulator width.
    function automatic logic [DIST_W-1:0] popcount(input logic [CHUNK_WIDTH-1:0] v);
        logic [DIST_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            cnt = cnt + DIST_W'(v[i]);
        end
        return cnt;
    endfunction

    // Zero-extend the difference vectors to the padded chunk boundary.
    assign w_xor_ns_in = PAD_W'(hv_test ^ hv_nonseizure);
    assign w_xor_sz_in = PAD_W'(hv_test ^ hv_seizure);

    // The operand registers shift right by one chunk per COUNT cycle, so the
    // current chunk is always the low CHUNK_WIDTH bits (no wide index mux).
    assign w_pop_ns = popcount(r_xor_ns[CHUNK_WIDTH-1:0]);
    assign w_pop_sz = popcount(r_xor_sz[CHUNK_WIDTH-1:0]);

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            r_state <= w_state_next;
        end
    end

    // Next-state decode: start only from IDLE, leave COUNT after the last chunk.
    always_comb begin
        // NOTE: default first so every path assigns it and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (en) w_state_next = S_COUNT;
            S_COUNT:   if (r_idx == LAST_IDX) w_state_next = S_COMPARE;
            S_COMPARE: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Datapath: latch operands, accumulate distances, register label and done.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_xor_ns  <= '0;
            r_xor_sz  <= '0;
            r_idx     <= '0;
            r_dist_ns <= '0;
            r_dist_sz <= '0;
            done      <= 1'b0;
            label     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_xor_ns  <= w_xor_ns_in;
                        r_xor_sz  <= w_xor_sz_in;
                        r_idx     <= '0;
                        r_dist_ns <= '0;
                        r_dist_sz <= '0;
                    end
                end
                S_COUNT: begin
                    r_dist_ns <= r_dist_ns + w_pop_ns;
                    r_dist_sz <= r_dist_sz + w_pop_sz;
                    r_xor_ns  <= r_xor_ns >> CHUNK_WIDTH;
                    r_xor_sz  <= r_xor_sz >> CHUNK_WIDTH;
                    r_idx     <= r_idx + IDX_W'(1);
                end
                S_COMPARE: begin
                    // Strict less-than: equal distances label non-seizure.
                    label <= (r_dist_sz < r_dist_ns);
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hv_similarity.sv
// Bench for hv_similarity: two instances (DIMENSIONS=5 with CHUNK_WIDTH=1
// and 2) share the operand inputs. Each start pushes the expected label and
// the cycle its done must appear into a per-instance queue; a negedge
// monitor compares done every cycle, pops on the expected done, and checks
// that label holds between results.
module tb_hv_similarity;

    localparam int D  = 5;
    localparam int N1 = 5;   // ceil(5/1)
    localparam int N2 = 3;   // ceil(5/2)

    logic         clk = 1'b0;
    logic         nrst = 1'b1;
    logic         en1 = 1'b0;
    logic         en2 = 1'b0;
    logic [D-1:0] hv_test = '0;
    logic [D-1:0] hv_ns   = '0;
    logic [D-1:0] hv_sz   = '0;
    logic         done1, label1, done2, label2;

    typedef struct {
        logic lbl;
        int   cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic last1  = 1'b0;
    logic last2  = 1'b0;
    logic exp_d1, exp_d2;

    hv_similarity #(.DIMENSIONS(D), .CHUNK_WIDTH(1)) u_dut1 (
        .clk(clk), .nrst(nrst), .en(en1),
        .hv_test(hv_test), .hv_nonseizure(hv_ns), .hv_seizure(hv_sz),
        .done(done1), .label(label1)
    );

    hv_similarity #(.DIMENSIONS(D), .CHUNK_WIDTH(2)) u_dut2 (
        .clk(clk), .nrst(nrst), .en(en2),
        .hv_test(hv_test), .hv_nonseizure(hv_ns), .hv_seizure(hv_sz),
        .done(done2), .label(label2)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge e, cyc == e when sampled at the negedge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference classifier: seizure only when strictly nearer to that prototype.
    function automatic logic model(input logic [D-1:0] t);
        return $countones(t ^ hv_sz) < $countones(t ^ hv_ns);
    endfunction

    // Monitor for the CHUNK_WIDTH=1 instance.
    always @(negedge clk) begin
        if (nrst === 1'b1) begin
            exp_d1 = (q1.size() > 0) && (q1[0].cyc == cyc);
            check("dut1 done", done1, exp_d1);
            if (exp_d1) begin
                check("dut1 label", label1, q1[0].lbl);
                last1 = q1[0].lbl;
                void'(q1.pop_front());
            end else begin
                check("dut1 label hold", label1, last1);
            end
        end
    end

    // Monitor for the CHUNK_WIDTH=2 instance.
    always @(negedge clk) begin
        if (nrst === 1'b1) begin
            exp_d2 = (q2.size() > 0) && (q2[0].cyc == cyc);
            check("dut2 done", done2, exp_d2);
            if (exp_d2) begin
                check("dut2 label", label2, q2[0].lbl);
                last2 = q2[0].lbl;
                void'(q2.pop_front());
            end else begin
                check("dut2 label hold", label2, last2);
            end
        end
    end

    // One-cycle en on instance 1; the en edge is the next rising edge (cyc+1)
    // and done is expected N1+1 edges after it.
    task automatic start1(input logic [D-1:0] t, input bit push);
        @(negedge clk);
        hv_test = t;
        en1     = 1'b1;
        if (push) q1.push_back('{model(t), cyc + 1 + N1 + 1});
        @(negedge clk);
        en1 = 1'b0;
    endtask

    task automatic start2(input logic [D-1:0] t);
        @(negedge clk);
        hv_test = t;
        en2     = 1'b1;
        q2.push_back('{model(t), cyc + 1 + N2 + 1});
        @(negedge clk);
        en2 = 1'b0;
    endtask

    // Wait (bounded) for both scoreboards to empty.
    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (q1.size() == 0 && q2.size() == 0) break;
            @(negedge clk);
            #1;
        end
        check("drain", q1.size() + q2.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // Reset for two cycles; outputs must be clear.
        #1 nrst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset done1", done1, 0);
        check("reset label1", label1, 0);
        check("reset done2", done2, 0);
        check("reset label2", label2, 0);
        nrst = 1'b1;

        // 1: distances 1 vs 4 -> 0, six cycles after en.
        hv_ns = 5'b00000;
        hv_sz = 5'b11111;
        start1(5'b00001, 1'b1);
        drain();

        // 2: 2 vs 3 -> 0, 3 vs 2 -> 1, 5 vs 0 -> 1.
        start1(5'b00101, 1'b1);
        drain();
        start1(5'b11010, 1'b1);
        drain();
        start1(5'b11111, 1'b1);
        drain();

        // en held high: second start on the edge after done, new label 0.
        @(negedge clk);
        hv_test = 5'b11010;
        en1     = 1'b1;
        q1.push_back('{model(5'b11010), cyc + 1 + N1 + 1});
        repeat (7) @(negedge clk);
        hv_test = 5'b00101;
        q1.push_back('{model(5'b00101), cyc + 1 + N1 + 1});
        @(negedge clk);
        en1 = 1'b0;
        drain();

        // 3: tie 1 vs 1 -> 0 (first set a 1 so the tie visibly clears it).
        start1(5'b11111, 1'b1);
        drain();
        hv_sz = 5'b00011;
        start1(5'b00001, 1'b1);
        drain();

        // 4: operand change after the en edge and a busy en are ignored.
        hv_sz = 5'b11111;
        start1(5'b11111, 1'b1);
        drain();
        start1(5'b00001, 1'b1);
        hv_test = 5'b11111;
        @(negedge clk);
        en1 = 1'b1;
        @(negedge clk);
        en1 = 1'b0;
        drain();

        // 5: async reset three cycles into an operation after a label of 1.
        start1(5'b11111, 1'b1);
        drain();
        start1(5'b00001, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        nrst  = 1'b0;
        last1 = 1'b0;
        last2 = 1'b0;
        #1;
        check("abort done1", done1, 0);
        check("abort label1", label1, 0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (10) @(negedge clk);

        // 6: CHUNK_WIDTH=2, partial last chunk, four cycles latency.
        start2(5'b11010);
        drain();
        start2(5'b00001);
        drain();
        hv_sz = 5'b00011;
        start2(5'b00001);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hv_similarity.md
Name:
hv_similarity

Overview:
- Associative-memory classifier stage of the HDC seizure-detection pipeline.
- Compares an encoded test hypervector against two class prototype hypervectors (non-seizure, seizure) by Hamming distance.
- Emits a one-bit label, 1 = seizure, plus a one-cycle done pulse.
- Multi-cycle, chunked popcount so that large DIMENSIONS do not need a single-cycle adder tree.

Parameters:
- DIMENSIONS, default 10000: hypervector width in bits; must be ≥ 1.
- CHUNK_WIDTH, default 1: bits popcounted per cycle per class; must be in 1..DIMENSIONS. The last chunk may be partial; bits past DIMENSIONS count as 0.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- nrst  input  1  reset, asynchronous and active-low; clears all state.
- en  input  1  start strobe, sampled on a rising clk edge; only honoured in IDLE.
- hv_test  input  DIMENSIONS  query hypervector.
- hv_nonseizure  input  DIMENSIONS  non-seizure class prototype.
- hv_seizure  input  DIMENSIONS  seizure class prototype.
- done  output  1  one-cycle pulse: a new label is valid.
- label  output  1  classification result; 1 = seizure, 0 = non-seizure. Registered and held until the next result.

Behaviour:
- Reset (nrst=0, asynchronous):
  - state=IDLE; done=0; label=0.
  - Chunk index and both distance accumulators cleared.
  - Latched operands may be cleared or left as-is.
- Define N = ceil(DIMENSIONS / CHUNK_WIDTH).
- Distance accumulators are $clog2(DIMENSIONS+1) bits wide and never overflow.
- States: IDLE → COUNT → COMPARE → IDLE.
- IDLE:
  - At the edge where en=1, latch hv_test XOR hv_nonseizure and hv_test XOR hv_seizure into internal registers.
  - Clear both accumulators and the chunk index; go to COUNT.
  - Inputs may change freely after this edge.
- COUNT:
  - Each edge adds the popcount of chunk[idx] of each XOR vector to its accumulator and increments idx.
  - After the edge that processes chunk N-1, go to COMPARE.
- COMPARE, one edge:
  - label <= 1 if dist_seizure < dist_nonseizure, else 0. A tie gives 0.
  - done <= 1; go to IDLE.
- done is high for exactly one cycle and cleared on the following edge.
- Latency: if en is sampled at edge k, done and the new label become visible after edge k+N+1 (N+1 cycles). Example: DIMENSIONS=5, CHUNK_WIDTH=1 gives 6 cycles.
- en while in COUNT or COMPARE is ignored; no queuing.
- en held high: a new operation starts at the first edge where state is IDLE. In this design that is the edge right after the done-setting edge, so done and the new start coincide for back-to-back operation.
- label changes only on the done-setting edge, otherwise stable.
- Asynchronous reset mid-operation aborts the operation: no done is produced and label returns to 0.

Test Plan:
1. DIMENSIONS=5, CHUNK_WIDTH=1, hv_nonseizure=00000, hv_seizure=11111, reset low for 2 cycles, then one-cycle en with hv_test=00001 → done pulses 6 cycles after the en edge; distances 1 vs 4; label=0.
2. Same prototypes, hv_test=00101 (distances 2 vs 3) → label=0; then hv_test=11010 (3 vs 2) → label=1; then hv_test=11111 (5 vs 0) → label=1. Each result: exactly one done pulse, and label holds between operations.
3. Tie: hv_nonseizure=00000, hv_seizure=00011, hv_test=00001 (1 vs 1) → label=0.
4. Input-change and busy-en robustness:
   - Change hv_test to 11111 one cycle after the en edge, and pulse en again mid-COUNT, with latched hv_test=00001.
   - Expect a single done after 6 cycles from the first en, with label=0; the second en produces no extra done.
5. Reset mid-operation: assert nrst=0 asynchronously three cycles after en, after a prior result of label=1 → done and label go to 0 immediately; no done after release until a new en.
6. Chunking: DIMENSIONS=5, CHUNK_WIDTH=2 (N=3, partial last chunk), hv_test=11010 → done after 4 cycles; label=1.
